// File: rtl/mmio_arbiter.sv
// Two-requester round-robin front end onto a single AXI-lite master port.
// Only one transaction is in flight; completions come back as one-cycle rsp_valid pulses.

package const_pkg;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        INIT,
        WRITE_1,
        WRITE_RESP,
        READ_1,
        READ_RESP
    } axi_mmio_state_t;
endpackage

module mmio_arbiter
    import const_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output resp_t               rsp_resp,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp
);

    axi_mmio_state_t r_state;
    logic            r_grant;
    logic            r_last_grant;

    logic [1:0]        w_req;
    logic              w_req_any;
    logic              w_gnt;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_aw_ok;
    logic              w_w_ok;

    // A requester whose completion is being signalled this cycle is still holding
    // req_valid; mask it so the same request is not granted twice.
    assign w_req     = req_valid & ~rsp_valid;
    assign w_req_any = |w_req;
    assign w_gnt     = (&w_req) ? ~r_last_grant : w_req[1];
    assign w_we      = req_we[w_gnt];
    assign w_addr    = w_gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign w_wdata   = w_gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign w_aw_ok = ~m_awvalid | m_awready;
    assign w_w_ok  = ~m_wvalid  | m_wready;

    // Transaction sequencer with registered AXI and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_resp     <= RESP_OKAY;
            m_awvalid    <= 1'b0;
            m_awaddr     <= '0;
            m_wvalid     <= 1'b0;
            m_wdata      <= '0;
            m_bready     <= 1'b0;
            m_arvalid    <= 1'b0;
            m_araddr     <= '0;
            m_rready     <= 1'b0;
        end else begin
            rsp_valid <= '0;
            unique case (r_state)
                INIT: begin
                    if (w_req_any) begin
                        r_grant      <= w_gnt;
                        r_last_grant <= w_gnt;
                        m_awaddr     <= w_addr;
                        m_araddr     <= w_addr;
                        m_wdata      <= w_wdata;
                        if (w_we) begin
                            r_state   <= WRITE_1;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= READ_1;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                WRITE_1: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                    end
                    if (m_wready) begin
                        m_wvalid <= 1'b0;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= WRITE_RESP;
                        m_bready <= 1'b1;
                    end
                end
                WRITE_RESP: begin
                    if (m_bvalid) begin
                        r_state            <= INIT;
                        m_bready           <= 1'b0;
                        rsp_resp           <= resp_t'(m_bresp);
                        rsp_valid[r_grant] <= 1'b1;
                    end
                end
                READ_1: begin
                    if (m_arready) begin
                        r_state   <= READ_RESP;
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                    end
                end
                READ_RESP: begin
                    if (m_rvalid) begin
                        r_state            <= INIT;
                        m_rready           <= 1'b0;
                        rsp_rdata          <= m_rdata;
                        rsp_resp           <= resp_t'(m_rresp);
                        rsp_valid[r_grant] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: the bench plays both requesters and the AXI-lite slave.
// Control outputs are compared as one vector {aw, w, b, ar, r, rsp_valid[1:0]}.

module tb_mmio_arbiter;
    import const_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    resp_t       rsp_resp;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    logic [6:0]  ctl;
    int          checks;
    int          errors;

    assign ctl = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid};

    mmio_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awaddr  (m_awaddr),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_bresp   (m_bresp),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000000);
        end
        checks++;
        if ({rsp_rdata, rsp_resp} !== 34'h0) begin
            errors++;
            $display("FAIL reset_rsp got rdata=%h resp=%b exp 0/0", rsp_rdata, rsp_resp);
        end
        rst = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        m_arready = 1'b1; m_rvalid = 1'b1;
        tick();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL idle_ctl got=%b exp=%b", ctl, 7'b0000000);
        end
    endtask

    // Seven reads; fresh request patterns exercise both priority directions.
    task automatic test_round_robin();
        logic [1:0]  pat [7] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
        logic        exp_i;
        logic [31:0] exp_addr;
        logic [6:0]  exp_ctl;
        req_we   = 2'b00;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        for (int k = 0; k < 7; k++) begin
            exp_i    = (k % 2) == 1;
            exp_addr = exp_i ? 32'h0000_0200 : 32'h0000_0100;
            exp_ctl  = exp_i ? 7'b0000010 : 7'b0000001;
            if (pat[k] != 2'b00) begin
                if (k != 0) tick();
                req_valid = pat[k];
            end
            m_rdata = 32'hA000_0000 + 32'(k);
            tick();
            checks++;
            if (ctl !== 7'b0001000 || m_araddr !== exp_addr) begin
                errors++;
                $display("FAIL rr_ar k=%0d ctl=%b araddr=%h exp ctl=%b araddr=%h",
                         k, ctl, m_araddr, 7'b0001000, exp_addr);
            end
            tick();
            checks++;
            if (ctl !== 7'b0000100) begin
                errors++;
                $display("FAIL rr_rready k=%0d got=%b exp=%b", k, ctl, 7'b0000100);
            end
            tick();
            checks++;
            if (ctl !== exp_ctl || rsp_rdata !== m_rdata || rsp_resp !== RESP_OKAY) begin
                errors++;
                $display("FAIL rr_rsp k=%0d ctl=%b rdata=%h exp ctl=%b rdata=%h",
                         k, ctl, rsp_rdata, exp_ctl, m_rdata);
            end
            req_valid[exp_i] = 1'b0;
        end
        tick();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL rr_idle got=%b exp=%b", ctl, 7'b0000000);
        end
    endtask

    task automatic test_write_basic();
        req_we    = 2'b01;
        req_addr  = {32'h0, 32'h0000_0010};
        req_wdata = {32'h0, 32'hDEAD_BEEF};
        m_bresp   = 2'b00;
        req_valid = 2'b01;
        tick();
        checks++;
        if (ctl !== 7'b1100000 || m_awaddr !== 32'h10 || m_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_aw ctl=%b awaddr=%h wdata=%h exp ctl=%b 10 deadbeef",
                     ctl, m_awaddr, m_wdata, 7'b1100000);
        end
        tick();
        checks++;
        if (ctl !== 7'b0010000) begin
            errors++;
            $display("FAIL wr_bready got=%b exp=%b", ctl, 7'b0010000);
        end
        tick();
        checks++;
        if (ctl !== 7'b0000001 || rsp_resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL wr_rsp ctl=%b resp=%b exp ctl=%b resp=00", ctl, rsp_resp, 7'b0000001);
        end
        req_valid = 2'b00;
        tick();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL wr_done got=%b exp=%b", ctl, 7'b0000000);
        end
    endtask

    task automatic test_write_w_late();
        req_we    = 2'b10;
        req_addr  = {32'h0000_0024, 32'h0};
        req_wdata = {32'h5555_AAAA, 32'h0};
        m_wready  = 1'b0;
        req_valid = 2'b10;
        tick();
        checks++;
        if (ctl !== 7'b1100000 || m_awaddr !== 32'h24) begin
            errors++;
            $display("FAIL wl_aw ctl=%b awaddr=%h exp ctl=%b awaddr=24", ctl, m_awaddr, 7'b1100000);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ctl !== 7'b0100000 || m_wdata !== 32'h5555_AAAA) begin
                errors++;
                $display("FAIL wl_wait c=%0d ctl=%b wdata=%h exp ctl=%b wdata=5555aaaa",
                         c, ctl, m_wdata, 7'b0100000);
            end
        end
        m_wready = 1'b1;
        tick();
        checks++;
        if (ctl !== 7'b0010000) begin
            errors++;
            $display("FAIL wl_bready got=%b exp=%b", ctl, 7'b0010000);
        end
        tick();
        checks++;
        if (ctl !== 7'b0000010) begin
            errors++;
            $display("FAIL wl_rsp got=%b exp=%b", ctl, 7'b0000010);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_read_slverr();
        req_we    = 2'b00;
        req_addr  = {32'h0, 32'h0000_0030};
        m_rdata   = 32'h0000_1234;
        m_rresp   = 2'b10;
        req_valid = 2'b01;
        tick();
        tick();
        tick();
        checks++;
        if (ctl !== 7'b0000001 || rsp_rdata !== 32'h1234 || rsp_resp !== RESP_SLVERR) begin
            errors++;
            $display("FAIL se_rsp ctl=%b rdata=%h resp=%b exp ctl=%b 1234 10",
                     ctl, rsp_rdata, rsp_resp, 7'b0000001);
        end
        req_valid = 2'b00;
        m_rdata   = 32'hFFFF_FFFF;
        m_rresp   = 2'b00;
        tick();
        checks++;
        if (ctl !== 7'b0000000 || rsp_rdata !== 32'h1234 || rsp_resp !== RESP_SLVERR) begin
            errors++;
            $display("FAIL se_hold ctl=%b rdata=%h resp=%b exp ctl=%b 1234 10",
                     ctl, rsp_rdata, rsp_resp, 7'b0000000);
        end
    endtask

    // Reset lands while stuck in READ_RESP; afterwards req0 must again win a contest.
    task automatic test_reset_mid();
        req_we    = 2'b00;
        req_addr  = {32'h0000_0044, 32'h0000_0040};
        m_rvalid  = 1'b0;
        req_valid = 2'b01;
        tick();
        tick();
        tick();
        checks++;
        if (ctl !== 7'b0000100) begin
            errors++;
            $display("FAIL rm_wait got=%b exp=%b", ctl, 7'b0000100);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ctl !== 7'b0000000 || rsp_rdata !== 32'h0 || rsp_resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL rm_rst ctl=%b rdata=%h resp=%b exp all zero", ctl, rsp_rdata, rsp_resp);
        end
        rst       = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h0BAD_F00D;
        req_valid = 2'b11;
        tick();
        checks++;
        if (ctl !== 7'b0001000 || m_araddr !== 32'h40) begin
            errors++;
            $display("FAIL rm_regrant ctl=%b araddr=%h exp ctl=%b araddr=40", ctl, m_araddr, 7'b0001000);
        end
        tick();
        tick();
        checks++;
        if (ctl !== 7'b0000001 || rsp_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rm_rsp ctl=%b rdata=%h exp ctl=%b 0badf00d", ctl, rsp_rdata, 7'b0000001);
        end
        req_valid = 2'b10;
        tick();
        checks++;
        if (ctl !== 7'b0001000 || m_araddr !== 32'h44) begin
            errors++;
            $display("FAIL rm_req1 ctl=%b araddr=%h exp ctl=%b araddr=44", ctl, m_araddr, 7'b0001000);
        end
        tick();
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_no_regrant();
        req_we    = 2'b00;
        req_addr  = {32'h0000_0050, 32'h0};
        req_valid = 2'b10;
        tick();
        tick();
        tick();
        checks++;
        if (ctl !== 7'b0000010) begin
            errors++;
            $display("FAIL ng_rsp got=%b exp=%b", ctl, 7'b0000010);
        end
        tick();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL ng_regrant got=%b exp=%b", ctl, 7'b0000000);
        end
        req_valid = 2'b00;
        tick();
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++;
            $display("FAIL ng_idle got=%b exp=%b", ctl, 7'b0000000);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;

        test_reset();
        test_round_robin();
        test_write_basic();
        test_write_w_late();
        test_read_slverr();
        test_reset_mid();
        test_no_regrant();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester request; held until that requester's rsp_valid.
REQ-006 SHALL have port req_we  input  2  per-requester 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  2*ADDR_W  per-requester address; requester i occupies slice i.
REQ-008 SHALL have port req_wdata  input  2*DATA_W  per-requester write data; requester i occupies slice i.
REQ-009 SHALL have port rsp_valid  output  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port rsp_rdata  output  DATA_W  read data; valid while any rsp_valid bit is high.
REQ-011 SHALL have port rsp_resp  output  2  resp_t (const_pkg) completion status.
REQ-012 SHALL have port m_awvalid  output  1  AXI-lite write-address valid.
REQ-013 SHALL have port m_awready  input  1  AXI-lite write-address ready.
REQ-014 SHALL have port m_awaddr  output  ADDR_W  AXI-lite write address.
REQ-015 SHALL have port m_wvalid  output  1  AXI-lite write-data valid; wstrb is fixed at all-ones downstream.
REQ-016 SHALL have port m_wready  input  1  AXI-lite write-data ready.
REQ-017 SHALL have port m_wdata  output  DATA_W  AXI-lite write data.
REQ-018 SHALL have port m_bvalid  input  1  AXI-lite write-response valid.
REQ-019 SHALL have port m_bready  output  1  AXI-lite write-response ready.
REQ-020 SHALL have port m_bresp  input  2  AXI-lite write response.
REQ-021 SHALL have port m_arvalid  output  1  AXI-lite read-address valid.
REQ-022 SHALL have port m_arready  input  1  AXI-lite read-address ready.
REQ-023 SHALL have port m_araddr  output  ADDR_W  AXI-lite read address.
REQ-024 SHALL have port m_rvalid  input  1  AXI-lite read-data valid.
REQ-025 SHALL have port m_rready  output  1  AXI-lite read-data ready.
REQ-026 SHALL have port m_rdata  input  DATA_W  AXI-lite read data.
REQ-027 SHALL have port m_rresp  input  2  AXI-lite read response.

Function
REQ-028 SHALL sequence with axi_mmio_state_t (const_pkg): INIT (idle), WRITE_1, WRITE_RESP, READ_1, READ_RESP; one transaction outstanding at a time.
REQ-029 SHALL arbitrate only in INIT, round-robin: grant the requester not granted last when both request; last_grant resets to 1, so requester 0 wins the first contest.
REQ-030 SHALL latch grant index, we, addr and wdata at grant; go to WRITE_1 if we=1, else READ_1; AXI valids assert the next cycle (registered outputs).
REQ-031 SHALL, in WRITE_1, assert m_awvalid and m_wvalid together.
REQ-032 SHALL drop each of m_awvalid and m_wvalid independently on its own handshake, in either order or the same cycle.
REQ-033 SHALL enter WRITE_RESP only once both the AW and W handshakes are done.
REQ-034 SHALL hold m_bready=1 in WRITE_RESP; on m_bvalid, capture m_bresp, go to INIT, and pulse rsp_valid[grant] the following cycle.
REQ-035 SHALL, in READ_1, assert m_arvalid until m_arready, then go to READ_RESP.
REQ-036 SHALL hold m_rready=1 in READ_RESP; on m_rvalid, capture m_rdata/m_rresp, go to INIT, and pulse rsp_valid[grant] the following cycle.
REQ-037 SHALL ignore req_valid[i] in any cycle where rsp_valid[i]=1, so a held request is not re-granted.
REQ-038 SHALL hold rsp_rdata and rsp_resp stable until the next capture; rsp_rdata on writes is don't-care.
REQ-039 SHALL hold m_awaddr, m_wdata and m_araddr stable while the matching valid is high.
REQ-040 SHALL keep m_bready and m_rready at 0 outside their RESP states; valid never drops before its ready.
REQ-041 SHALL require minimum latency of 3 cycles from grant to rsp_valid with zero-wait slave ready/valid, for both writes and reads.

Reset
REQ-042 SHALL, when rst=1 at a clock edge (including mid-transaction), go to INIT, set last_grant=1, zero all m_*valid, m_bready, m_rready, rsp_valid, rsp_rdata and rsp_resp, and drop the in-flight transaction with no rsp_valid.

Verification
REQ-043 SHALL cover: req0 write addr 0x10 data 0xDEADBEEF, zero-wait slave -> AW/W at cycle+1, rsp_valid=01 at cycle+3, rsp_resp=OKAY.
REQ-044 SHALL cover: both requesters read simultaneously after reset -> req0 served first, then req1; then both again -> req0 first, then req1.
REQ-045 SHALL cover: m_wready 3 cycles after m_awready -> m_awvalid drops first; WRITE_RESP entered only after the W handshake.
REQ-046 SHALL cover: read with m_rresp=SLVERR and m_rdata=0x1234 -> rsp_rdata=0x1234 and rsp_resp=SLVERR with a single-cycle rsp_valid.
REQ-047 SHALL cover: rst asserted in READ_RESP -> next cycle all outputs 0 and state INIT; a later request is granted normally.
REQ-048 SHALL cover: req1 keeps req_valid high in its rsp_valid cycle while req0 is idle -> no re-grant in that cycle.
